// File: rtl/odd_result_pipe_pkg.sv
// rtl/odd_result_pipe_pkg.sv - shared constants and entry layout for the result pipes
package odd_result_pipe_pkg;

   localparam int DEFAULT_DATA_W = 128;
   localparam int DEFAULT_ADDR_W = 7;
   localparam int ODD_DEPTH      = 7;
   localparam int EVEN_DEPTH     = 6;

   // Stage-bus entry layout, MSB-first: {valid, wr_en, ready, rt_addr, data}
   localparam int ENTRY_DATA_LSB = 0;

   function automatic int entry_addr_lsb(input int data_w);
      return data_w;
   endfunction

   function automatic int entry_ready_bit(input int data_w, input int addr_w);
      return data_w + addr_w;
   endfunction

   function automatic int entry_wr_en_bit(input int data_w, input int addr_w);
      return data_w + addr_w + 1;
   endfunction

   function automatic int entry_valid_bit(input int data_w, input int addr_w);
      return data_w + addr_w + 2;
   endfunction

endpackage

// File: rtl/odd_result_pipe_fw_match.sv
// rtl/odd_result_pipe_fw_match.sv - youngest-wins forwarding match for one source port
module odd_result_pipe_fw_match
   import odd_result_pipe_pkg::*;
#(
   parameter int DEPTH  = ODD_DEPTH,
   parameter int ADDR_W = DEFAULT_ADDR_W,
   parameter int DATA_W = DEFAULT_DATA_W
) (
   input  logic [DEPTH-1:0]        cand_valid,
   input  logic [DEPTH-1:0]        cand_ready,
   input  logic [DEPTH*ADDR_W-1:0] cand_addr,
   input  logic [DEPTH*DATA_W-1:0] cand_data,
   input  logic [ADDR_W-1:0]       src_addr,
   output logic                    hit,
   output logic                    stall,
   output logic [DATA_W-1:0]       data
);

   // Walk oldest to youngest so the lowest stage index is the last to win.
   always_comb begin
      hit   = 1'b0;
      stall = 1'b0;
      data  = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (cand_valid[i] && (cand_addr[i*ADDR_W +: ADDR_W] == src_addr)) begin
            hit   = 1'b1;
            stall = !cand_ready[i];
            data  = cand_data[i*DATA_W +: DATA_W];
         end
      end
   end

endmodule

// File: rtl/odd_result_pipe.sv
// rtl/odd_result_pipe.sv - DEPTH-stage result pipe with latency-aware forwarding,
// branch flush, occupancy count and writeback from the last stage
module odd_result_pipe
   import odd_result_pipe_pkg::*;
#(
   parameter int DATA_W   = DEFAULT_DATA_W,
   parameter int ADDR_W   = DEFAULT_ADDR_W,
   parameter int DEPTH    = ODD_DEPTH,
   parameter int NUM_SRC  = 3,
   parameter int LAT_W    = $clog2(DEPTH + 1),
   localparam int ENTRY_W = DATA_W + ADDR_W + 3
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      in_valid,
   input  logic                      in_wr_en,
   input  logic [ADDR_W-1:0]         in_rt_addr,
   input  logic [DATA_W-1:0]         in_data,
   input  logic [LAT_W-1:0]          in_lat,
   input  logic                      flush,
   input  logic [LAT_W-1:0]          kill_stage,
   input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
   output logic [NUM_SRC-1:0]        src_hit,
   output logic [NUM_SRC-1:0]        src_stall,
   output logic [NUM_SRC*DATA_W-1:0] src_data,
   output logic [DEPTH*ENTRY_W-1:0]  fw_st,
   output logic                      wb_en,
   output logic [ADDR_W-1:0]         wb_addr,
   output logic [DATA_W-1:0]         wb_data,
   output logic [LAT_W-1:0]          inflight
);

   localparam int ADDR_LSB  = entry_addr_lsb(DATA_W);
   localparam int READY_BIT = entry_ready_bit(DATA_W, ADDR_W);
   localparam int WR_BIT    = entry_wr_en_bit(DATA_W, ADDR_W);
   localparam int VALID_BIT = entry_valid_bit(DATA_W, ADDR_W);

   logic              st_valid [1:DEPTH];
   logic              st_wr_en [1:DEPTH];
   logic [LAT_W-1:0]  st_lat   [1:DEPTH];
   logic [ADDR_W-1:0] st_addr  [1:DEPTH];
   logic [DATA_W-1:0] st_data  [1:DEPTH];

   logic              issue_ok;
   logic [LAT_W-1:0]  issue_lat;
   logic              nxt_valid [1:DEPTH];
   logic [LAT_W-1:0]  nxt_count;

   logic [DEPTH-1:0]        cand_valid;
   logic [DEPTH-1:0]        cand_ready;
   logic [DEPTH*ADDR_W-1:0] cand_addr;
   logic [DEPTH*DATA_W-1:0] cand_data;

   always_comb begin
      issue_ok = in_valid && !flush;
      if (in_lat == '0)
         issue_lat = LAT_W'(1);
      else if (int'(in_lat) > DEPTH)
         issue_lat = LAT_W'(DEPTH);
      else
         issue_lat = in_lat;

      // A flush kills entries sitting in stages 1..kill_stage before they advance.
      nxt_valid[1] = issue_ok;
      for (int s = 2; s <= DEPTH; s++)
         nxt_valid[s] = st_valid[s-1] && !(flush && ((s - 1) <= int'(kill_stage)));

      nxt_count = '0;
      for (int s = 1; s <= DEPTH; s++)
         nxt_count = nxt_count + LAT_W'(nxt_valid[s]);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int s = 1; s <= DEPTH; s++) begin
            st_valid[s] <= 1'b0;
            st_wr_en[s] <= 1'b0;
            st_lat[s]   <= '0;
            st_addr[s]  <= '0;
            st_data[s]  <= '0;
         end
         inflight <= '0;
      end else begin
         st_valid[1] <= issue_ok;
         st_wr_en[1] <= issue_ok && in_wr_en;
         st_lat[1]   <= issue_ok ? issue_lat : '0;
         st_addr[1]  <= issue_ok ? in_rt_addr : '0;
         st_data[1]  <= issue_ok ? in_data : '0;
         for (int s = 2; s <= DEPTH; s++) begin
            st_valid[s] <= nxt_valid[s];
            st_wr_en[s] <= nxt_valid[s] && st_wr_en[s-1];
            st_lat[s]   <= nxt_valid[s] ? st_lat[s-1] : '0;
            st_addr[s]  <= nxt_valid[s] ? st_addr[s-1] : '0;
            st_data[s]  <= nxt_valid[s] ? st_data[s-1] : '0;
         end
         inflight <= nxt_count;
      end
   end

   always_comb begin
      fw_st      = '0;
      cand_valid = '0;
      cand_ready = '0;
      cand_addr  = '0;
      cand_data  = '0;
      for (int s = 1; s <= DEPTH; s++) begin
         cand_valid[s-1]                  = st_valid[s] && st_wr_en[s];
         cand_ready[s-1]                  = st_valid[s] && (s >= int'(st_lat[s]));
         cand_addr[(s-1)*ADDR_W +: ADDR_W] = st_addr[s];
         cand_data[(s-1)*DATA_W +: DATA_W] = st_data[s];
         fw_st[(s-1)*ENTRY_W + VALID_BIT]                   = st_valid[s];
         fw_st[(s-1)*ENTRY_W + WR_BIT]                      = st_wr_en[s];
         fw_st[(s-1)*ENTRY_W + READY_BIT]                   = cand_ready[s-1];
         fw_st[(s-1)*ENTRY_W + ADDR_LSB +: ADDR_W]          = st_addr[s];
         fw_st[(s-1)*ENTRY_W + ENTRY_DATA_LSB +: DATA_W]    = st_data[s];
      end
   end

   assign wb_en   = st_valid[DEPTH] && st_wr_en[DEPTH];
   assign wb_addr = st_addr[DEPTH];
   assign wb_data = st_data[DEPTH];

   for (genvar p = 0; p < NUM_SRC; p++) begin : g_src
      odd_result_pipe_fw_match #(
         .DEPTH  (DEPTH),
         .ADDR_W (ADDR_W),
         .DATA_W (DATA_W)
      ) u_match (
         .cand_valid (cand_valid),
         .cand_ready (cand_ready),
         .cand_addr  (cand_addr),
         .cand_data  (cand_data),
         .src_addr   (src_addr[p*ADDR_W +: ADDR_W]),
         .hit        (src_hit[p]),
         .stall      (src_stall[p]),
         .data       (src_data[p*DATA_W +: DATA_W])
      );
   end

endmodule

// File: tb/tb_odd_result_pipe.sv
// tb/tb_odd_result_pipe.sv - scoreboard bench for odd_result_pipe
module tb_odd_result_pipe;

   localparam int DW = 128;
   localparam int AW = 7;
   localparam int DEPTH = 7;
   localparam int NS = 3;
   localparam int LW = 3;
   localparam int EW = DW + AW + 3;
   localparam int RDY = DW + AW;
   localparam int VLD = DW + AW + 2;

   localparam int D2_DW = 16;
   localparam int D2_AW = 4;
   localparam int D2_DEPTH = 12;
   localparam int D2_LW = 4;
   localparam int D2_EW = D2_DW + D2_AW + 3;
   localparam int D2_RDY = D2_DW + D2_AW;

   logic clock = 1'b0;
   logic reset;
   logic in_valid, in_wr_en, flush;
   logic [AW-1:0] in_rt_addr;
   logic [DW-1:0] in_data;
   logic [LW-1:0] in_lat, kill_stage;
   logic [NS*AW-1:0] src_addr;
   logic [NS-1:0] src_hit, src_stall;
   logic [NS*DW-1:0] src_data;
   logic [DEPTH*EW-1:0] fw_st;
   logic wb_en;
   logic [AW-1:0] wb_addr;
   logic [DW-1:0] wb_data;
   logic [LW-1:0] inflight;

   logic d2_valid, d2_wr_en;
   logic [D2_AW-1:0] d2_rt_addr, d2_src_addr, d2_wb_addr;
   logic [D2_DW-1:0] d2_data, d2_src_data, d2_wb_data;
   logic [D2_LW-1:0] d2_lat, d2_inflight;
   logic d2_src_hit, d2_src_stall, d2_wb_en;
   logic [D2_DEPTH*D2_EW-1:0] d2_fw_st;

   always #5 clock = ~clock;

   odd_result_pipe #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .NUM_SRC(NS), .LAT_W(LW)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_wr_en(in_wr_en),
      .in_rt_addr(in_rt_addr), .in_data(in_data), .in_lat(in_lat), .flush(flush),
      .kill_stage(kill_stage), .src_addr(src_addr), .src_hit(src_hit), .src_stall(src_stall),
      .src_data(src_data), .fw_st(fw_st), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .inflight(inflight)
   );

   odd_result_pipe #(.DATA_W(D2_DW), .ADDR_W(D2_AW), .DEPTH(D2_DEPTH), .NUM_SRC(1), .LAT_W(D2_LW)) dut2 (
      .clock(clock), .reset(reset), .in_valid(d2_valid), .in_wr_en(d2_wr_en),
      .in_rt_addr(d2_rt_addr), .in_data(d2_data), .in_lat(d2_lat), .flush(1'b0),
      .kill_stage(4'd0), .src_addr(d2_src_addr), .src_hit(d2_src_hit), .src_stall(d2_src_stall),
      .src_data(d2_src_data), .fw_st(d2_fw_st), .wb_en(d2_wb_en), .wb_addr(d2_wb_addr),
      .wb_data(d2_wb_data), .inflight(d2_inflight)
   );

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      int            idx;
   } sb_t;

   sb_t sb_q[$];
   sb_t mon_e;
   int  edge_cnt = 0;
   int  n_checks = 0;
   int  n_fail = 0;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic st_ready(input int s);
      return fw_st[(s-1)*EW + RDY];
   endfunction

   function automatic logic st_vld(input int s);
      return fw_st[(s-1)*EW + VLD];
   endfunction

   function automatic logic [AW-1:0] st_addr(input int s);
      return fw_st[(s-1)*EW + DW +: AW];
   endfunction

   task automatic tick(input logic v, input logic w, input logic [AW-1:0] rt,
                       input logic [DW-1:0] d, input logic [LW-1:0] lat,
                       input logic fl, input logic [LW-1:0] ks);
      sb_t keep_q[$];
      in_valid = v; in_wr_en = w; in_rt_addr = rt; in_data = d; in_lat = lat;
      flush = fl; kill_stage = ks;
      @(posedge clock);
      edge_cnt++;
      if (fl) begin
         foreach (sb_q[i])
            if (edge_cnt - sb_q[i].idx > int'(ks)) keep_q.push_back(sb_q[i]);
         sb_q = keep_q;
      end
      if (v && w && !fl) sb_q.push_back('{rt, d, edge_cnt});
      #1;
      in_valid = 1'b0; in_wr_en = 1'b0; in_rt_addr = '0; in_data = '0; in_lat = '0;
      flush = 1'b0; kill_stage = '0;
      d2_valid = 1'b0; d2_wr_en = 1'b0; d2_rt_addr = '0; d2_data = '0; d2_lat = '0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
   endtask

   always @(negedge clock) begin
      if (reset && wb_en) begin
         if (sb_q.size() == 0) begin
            check_eq("wb_unexpected", 128'(wb_addr), 128'(1'b0) - 128'd1);
         end else begin
            mon_e = sb_q.pop_front();
            check_eq("wb_addr", 128'(wb_addr), 128'(mon_e.addr));
            check_eq("wb_data", wb_data, mon_e.data);
            check_eq("wb_timing", 128'(edge_cnt - mon_e.idx + 1), 128'(DEPTH));
         end
      end
   end

   initial begin
      logic [3:0] lat12;
      reset = 1'b0;
      in_valid = 1'b0; in_wr_en = 1'b0; in_rt_addr = '0; in_data = '0; in_lat = '0;
      flush = 1'b0; kill_stage = '0; src_addr = '0;
      d2_valid = 1'b0; d2_wr_en = 1'b0; d2_rt_addr = '0; d2_data = '0; d2_lat = '0;
      d2_src_addr = '0;
      repeat (2) @(posedge clock);
      #1;
      check_eq("rst_fw_st", 128'(|fw_st), 128'd0);
      check_eq("rst_wb_en", 128'(wb_en), 128'd0);
      check_eq("rst_inflight", 128'(inflight), 128'd0);
      check_eq("rst_hit", 128'(src_hit), 128'd0);
      check_eq("rst_stall", 128'(src_stall), 128'd0);
      check_eq("rst_data", 128'(|src_data), 128'd0);
      reset = 1'b1;

      // Latency 4: stalls in stages 1-3, forwards from stage 4, writes back from stage 7
      src_addr = {7'd0, 7'd0, 7'd5};
      tick(1'b1, 1'b1, 7'd5, 128'hAA, 3'd4, 1'b0, 3'd0);
      for (int k = 1; k <= DEPTH; k++) begin
         if (k > 1) idle(1);
         check_eq("lat_hit", 128'(src_hit[0]), 128'd1);
         check_eq("lat_stall", 128'(src_stall[0]), 128'(k < 4));
         if (k >= 4) check_eq("lat_data", src_data[DW-1:0], 128'hAA);
         check_eq("lat_inflight", 128'(inflight), 128'd1);
         check_eq("lat_wb_en", 128'(wb_en), 128'(k == DEPTH));
         if (k == DEPTH) check_eq("lat_wb_addr", 128'(wb_addr), 128'd5);
      end
      idle(1);
      check_eq("lat_drained", 128'(inflight), 128'd0);
      check_eq("lat_nohit", 128'(src_hit[0]), 128'd0);

      // Youngest unready writer hides an older ready one
      src_addr = {7'd0, 7'd0, 7'd9};
      tick(1'b1, 1'b1, 7'd9, 128'd1, 3'd2, 1'b0, 3'd0);
      check_eq("yw_first_stall", 128'(src_stall[0]), 128'd1);
      check_eq("yw_first_data", src_data[DW-1:0], 128'd1);
      tick(1'b1, 1'b1, 7'd9, 128'd2, 3'd6, 1'b0, 3'd0);
      for (int s = 1; s <= DEPTH; s++) begin
         if (s > 1) idle(1);
         check_eq("yw_hit", 128'(src_hit[0]), 128'd1);
         check_eq("yw_stall", 128'(src_stall[0]), 128'(s < 6));
         check_eq("yw_data", src_data[DW-1:0], 128'd2);
      end
      idle(1);
      check_eq("yw_drained", 128'(inflight), 128'd0);

      // Non-writing entry occupies the pipe but is invisible to forwarding/writeback
      src_addr = {7'd0, 7'd3, 7'd0};
      tick(1'b1, 1'b0, 7'd3, 128'h33, 3'd1, 1'b0, 3'd0);
      for (int k = 1; k <= DEPTH; k++) begin
         if (k > 1) idle(1);
         check_eq("nw_hit", 128'(src_hit[1]), 128'd0);
         check_eq("nw_wb_en", 128'(wb_en), 128'd0);
         check_eq("nw_inflight", 128'(inflight), 128'd1);
      end
      idle(1);
      check_eq("nw_drained", 128'(inflight), 128'd0);

      // Flush kill_stage=2 with stages 1-3 full and a same-cycle issue
      tick(1'b1, 1'b1, 7'd20, 128'h20, 3'd1, 1'b0, 3'd0);
      tick(1'b1, 1'b1, 7'd21, 128'h21, 3'd1, 1'b0, 3'd0);
      tick(1'b1, 1'b1, 7'd22, 128'h22, 3'd1, 1'b0, 3'd0);
      check_eq("fl_pre_inflight", 128'(inflight), 128'd3);
      tick(1'b1, 1'b1, 7'd23, 128'h23, 3'd1, 1'b1, 3'd2);
      for (int s = 1; s <= 3; s++) check_eq("fl_killed", 128'(st_vld(s)), 128'd0);
      check_eq("fl_st4_valid", 128'(st_vld(4)), 128'd1);
      check_eq("fl_st4_addr", 128'(st_addr(4)), 128'd20);
      check_eq("fl_inflight", 128'(inflight), 128'd1);
      idle(4);
      check_eq("fl_drained", 128'(inflight), 128'd0);
      tick(1'b1, 1'b1, 7'd24, 128'h24, 3'd1, 1'b0, 3'd0);
      tick(1'b1, 1'b1, 7'd25, 128'h25, 3'd1, 1'b0, 3'd0);
      tick(1'b0, 1'b0, 7'd0, 128'h0, 3'd0, 1'b1, 3'd7);
      check_eq("flall_inflight", 128'(inflight), 128'd0);
      check_eq("flall_fw_st", 128'(|fw_st), 128'd0);
      idle(DEPTH);

      // Latency clamps
      src_addr = {7'd11, 7'd0, 7'd0};
      tick(1'b1, 1'b1, 7'd11, 128'h11, 3'd0, 1'b0, 3'd0);
      check_eq("clamp0_ready", 128'(st_ready(1)), 128'd1);
      check_eq("clamp0_stall", 128'(src_stall[2]), 128'd0);
      idle(DEPTH);
      src_addr = {7'd12, 7'd0, 7'd0};
      lat12 = 4'd12;
      tick(1'b1, 1'b1, 7'd12, 128'h12, lat12[2:0], 1'b0, 3'd0);
      for (int s = 1; s <= DEPTH; s++) begin
         if (s > 1) idle(1);
         check_eq("wrap_ready", 128'(st_ready(s)), 128'(s >= 4));
         check_eq("wrap_stall", 128'(src_stall[2]), 128'(s < 4));
      end
      idle(1);

      d2_valid = 1'b1; d2_wr_en = 1'b1; d2_rt_addr = 4'd2; d2_data = 16'h55; d2_lat = 4'd15;
      d2_src_addr = 4'd2;
      tick(1'b0, 1'b0, 7'd0, 128'h0, 3'd0, 1'b0, 3'd0);
      for (int s = 1; s <= D2_DEPTH; s++) begin
         if (s > 1) idle(1);
         check_eq("d2_ready", 128'(d2_fw_st[(s-1)*D2_EW + D2_RDY]), 128'(s == D2_DEPTH));
         check_eq("d2_wb_en", 128'(d2_wb_en), 128'(s == D2_DEPTH));
      end
      idle(1);
      check_eq("d2_drained", 128'(d2_inflight), 128'd0);

      // Asynchronous reset with four entries in flight
      src_addr = {7'd0, 7'd0, 7'd30};
      for (int i = 0; i < 4; i++)
         tick(1'b1, 1'b1, 7'(30 + i), 128'(i + 1), 3'd1, 1'b0, 3'd0);
      check_eq("mr_pre_inflight", 128'(inflight), 128'd4);
      check_eq("mr_pre_hit", 128'(src_hit[0]), 128'd1);
      #2;
      reset = 1'b0;
      #1;
      check_eq("mr_fw_st", 128'(|fw_st), 128'd0);
      check_eq("mr_wb_en", 128'(wb_en), 128'd0);
      check_eq("mr_inflight", 128'(inflight), 128'd0);
      check_eq("mr_hit", 128'(src_hit[0]), 128'd0);
      sb_q.delete();
      @(posedge clock);
      #1;
      reset = 1'b1;
      idle(2);
      check_eq("mr_post_inflight", 128'(inflight), 128'd0);

      check_eq("sb_empty", 128'(sb_q.size()), 128'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
